// File: rtl/apb_pkg.sv
// -----------------------------------------------------------------------------
// apb_pkg
//   Shared types and constants for the APB4 requester, its address decoder,
//   and any completer models or benches that interpret the response code.
//
//   apb_resp_e       : 2-bit response code returned on the response port
//   apb_req_state_e  : requester FSM state encoding
//   APB_RESP_*       : response-code constants for non-enum consumers
//   idx_width()      : width of a completer index for a given completer count
// -----------------------------------------------------------------------------
package apb_pkg;

  typedef enum logic [1:0] {
    OKAY    = 2'b00,
    SLVERR  = 2'b01,
    DECERR  = 2'b10,
    TIMEOUT = 2'b11
  } apb_resp_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10,
    RESP   = 2'b11
  } apb_req_state_e;

  localparam logic [1:0] APB_RESP_OKAY    = 2'b00;
  localparam logic [1:0] APB_RESP_SLVERR  = 2'b01;
  localparam logic [1:0] APB_RESP_DECERR  = 2'b10;
  localparam logic [1:0] APB_RESP_TIMEOUT = 2'b11;

  // A single completer still needs a 1-bit index so port widths stay legal.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_addr_decoder.sv
// -----------------------------------------------------------------------------
// apb_addr_decoder
//   Purely combinational decode of a byte address onto one of NUM_SLAVES
//   completers. Each completer owns a 2**SLAVE_ADDR_BITS byte window, so the
//   completer index is addr >> SLAVE_ADDR_BITS.
//
//   Ports:
//     addr    in  [ADDR_WIDTH]  byte address of the command
//     idx     out [IDX_W]       completer index (valid only when !dec_err)
//     sel     out [NUM_SLAVES]  one-hot select, all zero on decode error
//     dec_err out 1             index out of range or address not aligned
//                               to the data bus width
// -----------------------------------------------------------------------------
module apb_addr_decoder
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned NUM_SLAVES      = 4,
  parameter int unsigned SLAVE_ADDR_BITS = 12
) (
  input  logic [ADDR_WIDTH-1:0]              addr,
  output logic [idx_width(NUM_SLAVES)-1:0]   idx,
  output logic [NUM_SLAVES-1:0]              sel,
  output logic                               dec_err
);

  localparam int unsigned IDX_W = idx_width(NUM_SLAVES);
  localparam int unsigned LSB_W = $clog2(DATA_WIDTH / 8);

  logic [ADDR_WIDTH-1:0] full_idx;
  logic                  out_of_range;
  logic                  misaligned;
  logic                  unused_offset;

  // The full shifted address is compared, so high address bits beyond the
  // last completer window are caught as out of range rather than aliased.
  assign full_idx     = addr >> SLAVE_ADDR_BITS;
  assign out_of_range = (full_idx >= ADDR_WIDTH'(NUM_SLAVES));
  assign idx          = full_idx[IDX_W-1:0];

  // An 8-bit bus has no alignment constraint.
  if (LSB_W > 0) begin : g_align
    assign misaligned = |addr[LSB_W-1:0];
  end else begin : g_no_align
    assign misaligned = 1'b0;
  end

  assign dec_err = out_of_range | misaligned;

  // The in-window offset is decoded by the completer, not here.
  assign unused_offset = ^addr[SLAVE_ADDR_BITS-1:0];

  always_comb begin
    // NOTE: default first so every path assigns sel and no latch is inferred.
    sel = '0;
    if (!dec_err) sel[idx] = 1'b1;
  end

endmodule

// File: rtl/apb_requester.sv
// -----------------------------------------------------------------------------
// apb_requester
//   APB4 requester. Accepts one read/write command at a time on a valid/ready
//   command port, decodes it to a completer, runs SETUP/ACCESS, and returns
//   read data plus a response code on a valid/ready response port.
//
//   Ports:
//     pclk, presetn          clock, asynchronous active-low reset
//     cmd_valid/cmd_ready    command handshake (ready only in IDLE)
//     cmd_write/addr/wdata/strb  command payload
//     rsp_valid/rsp_ready    response handshake
//     rsp_rdata, rsp_resp    read data (0 for writes/errors), response code
//     psel, penable, pwrite, paddr, pwdata, pstrb   APB requester outputs
//     prdata, pready, pslverr                       per-completer APB inputs
//
//   Build option: define APB_REQ_TIMEOUT_EN to abort an ACCESS phase that
//   lasts TIMEOUT_CYCLES cycles without pready, reporting TIMEOUT.
// -----------------------------------------------------------------------------
module apb_requester
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned NUM_SLAVES      = 4,
  parameter int unsigned SLAVE_ADDR_BITS = 12,
  parameter int unsigned TIMEOUT_CYCLES  = 16
) (
  input  logic                             pclk,
  input  logic                             presetn,
  // command port
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic                             cmd_write,
  input  logic [ADDR_WIDTH-1:0]            cmd_addr,
  input  logic [DATA_WIDTH-1:0]            cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0]          cmd_strb,
  // response port
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic [1:0]                       rsp_resp,
  // APB requester side
  output logic [NUM_SLAVES-1:0]            psel,
  output logic                             penable,
  output logic                             pwrite,
  output logic [ADDR_WIDTH-1:0]            paddr,
  output logic [DATA_WIDTH-1:0]            pwdata,
  output logic [DATA_WIDTH/8-1:0]          pstrb,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] prdata,
  input  logic [NUM_SLAVES-1:0]            pready,
  input  logic [NUM_SLAVES-1:0]            pslverr
);

  localparam int unsigned IDX_W = idx_width(NUM_SLAVES);

  // Elaboration-time parameter sanity.
  if (!(DATA_WIDTH == 8 || DATA_WIDTH == 16 || DATA_WIDTH == 32 || DATA_WIDTH == 64))
  begin : g_bad_data_width
    $error("apb_requester: DATA_WIDTH must be 8, 16, 32 or 64");
  end
  if (NUM_SLAVES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_counts
    $error("apb_requester: NUM_SLAVES and TIMEOUT_CYCLES must be at least 1");
  end

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0]      dec_idx;
  logic [NUM_SLAVES-1:0] dec_sel;
  logic                  dec_err;

  apb_addr_decoder #(
    .ADDR_WIDTH      (ADDR_WIDTH),
    .DATA_WIDTH      (DATA_WIDTH),
    .NUM_SLAVES      (NUM_SLAVES),
    .SLAVE_ADDR_BITS (SLAVE_ADDR_BITS)
  ) u_addr_decoder (
    .addr    (cmd_addr),
    .idx     (dec_idx),
    .sel     (dec_sel),
    .dec_err (dec_err)
  );

  // ---------------------------------------------------------------------------
  // State and the selected completer's return signals
  // ---------------------------------------------------------------------------
  apb_req_state_e        state;
  logic [IDX_W-1:0]      idx_q;
  logic                  sel_ready;
  logic                  sel_slverr;
  logic [DATA_WIDTH-1:0] sel_rdata;

  // Only the addressed completer's return path is ever looked at.
  assign sel_ready  = pready[idx_q];
  assign sel_slverr = pslverr[idx_q];
  assign sel_rdata  = prdata[idx_q*DATA_WIDTH +: DATA_WIDTH];

  assign cmd_ready = (state == IDLE);

`ifdef APB_REQ_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] access_cnt;
`endif

  // ---------------------------------------------------------------------------
  // FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      // NOTE: the payload registers are reset as well; every output is
      // defined as 0 in reset, not just the control bits.
      state     <= IDLE;
      idx_q     <= '0;
      psel      <= '0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      pstrb     <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp  <= OKAY;
`ifdef APB_REQ_TIMEOUT_EN
      access_cnt <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments throughout, so every decision below
      // sees the values from before this clock edge.
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            if (dec_err) begin
              // Bad address: answer immediately, never touch the APB bus.
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_resp  <= DECERR;
              rsp_rdata <= '0;
            end else begin
              state  <= SETUP;
              idx_q  <= dec_idx;
              psel   <= dec_sel;
              pwrite <= cmd_write;
              paddr  <= cmd_addr;
              pwdata <= cmd_write ? cmd_wdata : '0;
              pstrb  <= cmd_write ? cmd_strb  : '0;
            end
          end
        end

        SETUP: begin
          state   <= ACCESS;
          penable <= 1'b1;
`ifdef APB_REQ_TIMEOUT_EN
          access_cnt <= '0;
`endif
        end

        ACCESS: begin
          if (sel_ready) begin
            state     <= RESP;
            psel      <= '0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_resp  <= sel_slverr ? SLVERR : OKAY;
            rsp_rdata <= (!pwrite && !sel_slverr) ? sel_rdata : '0;
          end
`ifdef APB_REQ_TIMEOUT_EN
          // pready on the last permitted cycle is handled above and wins.
          else if (access_cnt == CNT_LAST) begin
            state     <= RESP;
            psel      <= '0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_resp  <= TIMEOUT;
            rsp_rdata <= '0;
          end else begin
            access_cnt <= access_cnt + 1'b1;
          end
`endif
        end

        RESP: begin
          // rsp_rdata/rsp_resp are untouched here, so they hold while stalled.
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_requester.sv
// -----------------------------------------------------------------------------
// tb_apb_requester
//   Self-checking bench for apb_requester (default parameters). Each
//   transaction's expected bus activity, latency, response code and read data
//   are derived from the address map and completer behaviour chosen for it.
//   Timeout scenarios are included when APB_REQ_TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------
module tb_apb_requester;
  import apb_pkg::*;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int NS  = 4;
  localparam int SAB = 12;
  localparam int TO  = 16;
  localparam int SW  = DW / 8;

  logic              pclk = 1'b0;
  logic              presetn;
  logic              cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0]     cmd_addr;
  logic [DW-1:0]     cmd_wdata;
  logic [SW-1:0]     cmd_strb;
  logic              rsp_valid, rsp_ready;
  logic [DW-1:0]     rsp_rdata;
  logic [1:0]        rsp_resp;
  logic [NS-1:0]     psel;
  logic              penable, pwrite;
  logic [AW-1:0]     paddr;
  logic [DW-1:0]     pwdata;
  logic [SW-1:0]     pstrb;
  logic [NS*DW-1:0]  prdata;
  logic [NS-1:0]     pready, pslverr;

  apb_requester #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLAVES(NS),
    .SLAVE_ADDR_BITS(SAB), .TIMEOUT_CYCLES(TO)
  ) dut (
    .pclk(pclk), .presetn(presetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready),
    .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One complete transaction. Called right after a falling edge.
  //   waits : wait states the addressed completer inserts before pready
  //   err   : completer answers with pslverr
  //   rd    : data the addressed completer returns
  //   hold  : cycles rsp_ready stays low once rsp_valid is up
  task automatic do_txn(input logic wr, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wd, input logic [SW-1:0] st,
                        input int waits, input logic err, input logic [DW-1:0] rd,
                        input int hold, input string tag);
    logic [AW-1:0] full_idx;
    logic          dec, timed_out;
    int            idx, exp_lat;
    logic [1:0]    exp_resp;
    logic [DW-1:0] exp_rdata, exp_pwdata;
    logic [SW-1:0] exp_pstrb;
    logic [NS-1:0] exp_psel;

    // Reference behaviour from the address map and the response rules.
    full_idx  = addr >> SAB;
    dec       = (full_idx >= AW'(NS)) || (addr % SW != 0);
    idx       = dec ? 0 : int'(full_idx);
`ifdef APB_REQ_TIMEOUT_EN
    timed_out = !dec && (waits >= TO);
`else
    timed_out = 1'b0;
`endif
    exp_lat   = dec ? 1 : (timed_out ? 2 + TO : 3 + waits);
    exp_resp  = dec ? 2'd2 : (timed_out ? 2'd3 : (err ? 2'd1 : 2'd0));
    exp_rdata = (exp_resp == 2'd0 && !wr) ? rd : '0;
    exp_psel  = dec ? '0 : NS'(1 << idx);
    exp_pwdata = wr ? wd : '0;
    exp_pstrb  = wr ? st : '0;

    // Completer fabric: unaddressed completers look ready and erroring with
    // junk data, so any mis-indexing shows up.
    for (int s = 0; s < NS; s++)
      prdata[s*DW +: DW] = (s == idx && !dec) ? rd : DW'($urandom());
    pslverr = NS'($urandom());
    pready  = '1;
    if (!dec) begin
      pslverr[idx] = err;
      pready[idx]  = 1'b0;
    end

    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wd;
    cmd_strb  = st;
    check({tag, " cmd_ready idle"}, cmd_ready, 1'b1);
    @(posedge pclk);
    @(negedge pclk);
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom());
    cmd_addr  = AW'($urandom());
    cmd_wdata = DW'($urandom());
    cmd_strb  = SW'($urandom());

    for (int c = 1; c <= exp_lat; c++) begin
      check($sformatf("%s c%0d rsp_valid", tag, c), rsp_valid, (c == exp_lat));
      check($sformatf("%s c%0d cmd_ready", tag, c), cmd_ready, 1'b0);
      if (c < exp_lat) begin
        check($sformatf("%s c%0d psel", tag, c), psel, exp_psel);
        check($sformatf("%s c%0d penable", tag, c), penable, (c >= 2));
        check($sformatf("%s c%0d paddr", tag, c), paddr, addr);
        check($sformatf("%s c%0d pwrite", tag, c), pwrite, wr);
        check($sformatf("%s c%0d pwdata", tag, c), pwdata, exp_pwdata);
        check($sformatf("%s c%0d pstrb", tag, c), pstrb, exp_pstrb);
        if (!dec) pready[idx] = (c == 2 + waits);
        @(posedge pclk);
        @(negedge pclk);
      end else begin
        check($sformatf("%s psel resp", tag), psel, '0);
        check($sformatf("%s penable resp", tag), penable, 1'b0);
        check($sformatf("%s rsp_resp", tag), rsp_resp, exp_resp);
        check($sformatf("%s rsp_rdata", tag), rsp_rdata, exp_rdata);
      end
    end
    if (!dec) pready[idx] = 1'b0;

    // Response backpressure.
    for (int h = 1; h <= hold; h++) begin
      rsp_ready = 1'b0;
      @(posedge pclk);
      @(negedge pclk);
      check($sformatf("%s hold%0d rsp_valid", tag, h), rsp_valid, 1'b1);
      check($sformatf("%s hold%0d rsp_resp", tag, h), rsp_resp, exp_resp);
      check($sformatf("%s hold%0d rsp_rdata", tag, h), rsp_rdata, exp_rdata);
      check($sformatf("%s hold%0d cmd_ready", tag, h), cmd_ready, 1'b0);
    end
    rsp_ready = 1'b1;
    @(posedge pclk);
    @(negedge pclk);
    rsp_ready = 1'b0;
    check({tag, " rsp_valid done"}, rsp_valid, 1'b0);
    check({tag, " cmd_ready done"}, cmd_ready, 1'b1);
  endtask

  // Hard stop in case the bench itself gets stuck.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic          wr, err;
    logic [AW-1:0] addr;
    logic [11:0]   off;
    int            sl;

    presetn   = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    cmd_strb  = '0;
    rsp_ready = 1'b0;
    prdata    = '0;
    pready    = '0;
    pslverr   = '0;

    // Reset state.
    @(negedge pclk);
    @(negedge pclk);
    check("reset psel", psel, '0);
    check("reset penable", penable, 1'b0);
    check("reset paddr", paddr, '0);
    check("reset rsp_valid", rsp_valid, 1'b0);
    check("reset rsp_resp", rsp_resp, 2'b00);
    check("reset cmd_ready", cmd_ready, 1'b1);
    presetn = 1'b1;
    @(negedge pclk);
    check("post-reset cmd_ready", cmd_ready, 1'b1);

    // Directed scenarios.
    do_txn(1'b0, 32'h0000_1004, '0, '0, 0, 1'b0, 32'hDEAD_BEEF, 0, "rd_zero_wait");
    do_txn(1'b1, 32'h0000_0008, 32'hA5A5_0001, 4'b0011, 3, 1'b0, 32'h1111_2222, 0, "wr_3wait");
    do_txn(1'b0, 32'h0000_0003, '0, '0, 0, 1'b0, 32'h0, 0, "decerr_misaligned");
    do_txn(1'b1, 32'h0000_4000, 32'h5555_AAAA, 4'hF, 0, 1'b0, 32'h0, 0, "decerr_range");
    do_txn(1'b0, 32'h0000_2010, '0, '0, 1, 1'b1, 32'hCAFE_F00D, 0, "rd_slverr");
    do_txn(1'b1, 32'h0000_3ffc, 32'h0BAD_0BAD, 4'b1000, 2, 1'b1, 32'h0, 0, "wr_slverr");
    do_txn(1'b0, 32'h0000_0ff0, '0, '0, 2, 1'b0, 32'h1357_9BDF, 5, "rd_backpressure");

    // Reset pulse in the middle of ACCESS.
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 32'h0000_2010;
    cmd_wdata = 32'h1234_5678;
    cmd_strb  = 4'hF;
    pready    = '0;
    @(posedge pclk);
    @(negedge pclk);
    cmd_valid = 1'b0;
    @(posedge pclk);
    @(negedge pclk);
    check("rst_mid penable before", penable, 1'b1);
    #2 presetn = 1'b0;
    #1;
    check("rst_mid psel", psel, '0);
    check("rst_mid penable", penable, 1'b0);
    check("rst_mid pwrite", pwrite, 1'b0);
    check("rst_mid paddr", paddr, '0);
    check("rst_mid pwdata", pwdata, '0);
    check("rst_mid pstrb", pstrb, '0);
    check("rst_mid rsp_valid", rsp_valid, 1'b0);
    @(negedge pclk);
    presetn = 1'b1;
    @(negedge pclk);
    check("rst_mid cmd_ready after", cmd_ready, 1'b1);
    check("rst_mid rsp_valid after", rsp_valid, 1'b0);
    check("rst_mid psel after", psel, '0);
    do_txn(1'b0, 32'h0000_3008, '0, '0, 0, 1'b0, 32'h2468_ACE0, 0, "rd_after_reset");

`ifdef APB_REQ_TIMEOUT_EN
    do_txn(1'b0, 32'h0000_1000, '0, '0, 40, 1'b0, 32'hFFFF_0000, 0, "timeout");
    do_txn(1'b0, 32'h0000_1000, '0, '0, TO - 1, 1'b0, 32'h7777_8888, 0, "ready_last_cycle");
`endif

    // Randomized transactions over valid, misaligned and unmapped addresses.
    for (int t = 0; t < 24; t++) begin
      wr  = 1'($urandom());
      err = ($urandom_range(0, 3) == 0);
      sl  = $urandom_range(0, 5);
      off = 12'($urandom());
      if ($urandom_range(0, 3) != 0) off[1:0] = 2'b00;
      addr = (AW'(sl) << SAB) | AW'(off);
      if ($urandom_range(0, 9) == 0) addr[AW-1] = 1'b1;
      do_txn(wr, addr, DW'($urandom()), SW'($urandom()), $urandom_range(0, 4),
             err, DW'($urandom()), $urandom_range(0, 2), $sformatf("rand%0d", t));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
